// File: rtl/wbuffer_axi_line_writer_if.sv
// Handshake bundles for the write-buffer line drain: line side (buffer -> writer)
// and the AXI3 write channels (writer -> memory).
interface wbuffer_line_if;
  logic         line_req;
  logic         line_ack;
  logic [26:0]  line_paddr;
  logic [255:0] line_data;
  logic         line_done;
  logic         line_err;
  logic         busy;

  modport master (
    output line_req, line_paddr, line_data,
    input  line_ack, line_done, line_err, busy
  );
  modport slave (
    input  line_req, line_paddr, line_data,
    output line_ack, line_done, line_err, busy
  );
endinterface

interface wbuffer_axi_wr_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/wbuffer_axi_line_writer.sv
// Drains one 32-byte write-buffer line as a single 8-beat AXI3 INCR burst (AW, W, B),
// one line in flight; reports completion and slave error back to the buffer.
//
// state | meaning
// IDLE  | waiting for line_req; acks and latches the line in the same cycle
// ADDR  | awvalid high, holding awaddr until awready
// DATA  | streaming beats 0..7, wlast on beat 7
// RESP  | bready high, waiting for bvalid; line_done/line_err pulse on it
module wbuffer_axi_line_writer #(
  parameter logic [3:0] AXI_ID  = 4'd1,
  parameter logic [3:0] AWCACHE = 4'd0
) (
  input  logic             clk,
  input  logic             rst,
  wbuffer_line_if.slave    line_if,
  wbuffer_axi_wr_if.master axi
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e       state_q, state_d;
  logic [2:0]   beat_q, beat_d;
  logic [26:0]  paddr_q, paddr_d;
  logic [255:0] data_q, data_d;
  logic         awvalid_q, wvalid_q, bready_q, busy_q;
  logic         ack, aw_hs, w_hs, b_hs;

  assign ack   = (state_q == IDLE) && line_if.line_req;
  assign aw_hs = awvalid_q && axi.awready;
  assign w_hs  = wvalid_q && axi.wready;
  assign b_hs  = bready_q && axi.bvalid;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    paddr_d = paddr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (ack) begin
        state_d = ADDR;
        beat_d  = 3'd0;
        paddr_d = line_if.line_paddr;
        data_d  = line_if.line_data;
      end
      ADDR: if (aw_hs) state_d = DATA;
      DATA: if (w_hs) begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = RESP;
      end
      RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel valids/ready and busy are registered from the next state so they
  // rise and fall exactly with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= 3'd0;
      paddr_q   <= '0;
      data_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      paddr_q   <= paddr_d;
      data_q    <= data_d;
      awvalid_q <= (state_d == ADDR);
      wvalid_q  <= (state_d == DATA);
      bready_q  <= (state_d == RESP);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign line_if.line_ack  = ack;
  assign line_if.line_done = (state_q == RESP) && axi.bvalid;
  assign line_if.line_err  = (state_q == RESP) && axi.bvalid && (axi.bresp != 2'b00);
  assign line_if.busy      = busy_q;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = {paddr_q, 5'b0};
  assign axi.awlen   = 8'd7;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = AWCACHE;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;

  assign axi.wid    = AXI_ID;
  assign axi.wdata  = data_q[{beat_q, 5'b0} +: 32];
  assign axi.wstrb  = 4'hF;
  assign axi.wlast  = wvalid_q && (beat_q == 3'd7);
  assign axi.wvalid = wvalid_q;

  assign axi.bready = bready_q;

  // Single outstanding write, so the response ID carries no information.
  logic unused_bid;
  assign unused_bid = ^axi.bid;

endmodule

// File: tb/tb_wbuffer_axi_line_writer.sv
// Scoreboard bench for the line writer: stimulus pushes expected AW/W/B results,
// a negedge monitor pops and compares on each DUT handshake.
module tb_wbuffer_axi_line_writer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wbuffer_line_if   line_if ();
  wbuffer_axi_wr_if axi ();

  wbuffer_axi_line_writer #(.AXI_ID(4'd1), .AWCACHE(4'd0)) dut (
    .clk     (clk),
    .rst     (rst),
    .line_if (line_if),
    .axi     (axi)
  );

  typedef struct packed {logic [31:0] d; logic last;} wexp_t;

  logic [31:0] aw_q[$];
  wexp_t       w_q[$];
  logic        done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // responder knobs
  int       aw_wait   = 0;
  bit       w_alt     = 0;
  bit       w_tog     = 0;
  logic [1:0] resp_mode = 2'b00;

  // monitor state
  bit          aw_seen = 0;
  int          line_w_cnt = 0;
  int          aw_cyc = 0, first_w_cyc = 0;
  int          axi_act_cnt = 0;
  bit          aw_stall_prev = 0, w_stall_prev = 0;
  logic [31:0] aw_prev;
  logic [32:0] w_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI slave model
  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bid     = 4'd1;
    forever begin
      @(posedge clk);
      #1;
      if (axi.awvalid && aw_wait > 0) begin
        axi.awready = 1'b0;
        aw_wait--;
      end else begin
        axi.awready = axi.awvalid;
      end
      if (w_alt) begin
        w_tog = ~w_tog;
        axi.wready = w_tog;
      end else begin
        axi.wready = 1'b1;
      end
      axi.bvalid = axi.bready;
      axi.bresp  = axi.bready ? resp_mode : 2'b00;
    end
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      aw_stall_prev = 0;
      w_stall_prev  = 0;
    end else begin
      if (line_if.line_ack) check("ack_only_idle", line_if.busy, 0);
      if (aw_stall_prev) begin
        check("aw_hold_valid", axi.awvalid, 1);
        check("aw_hold_addr", axi.awaddr, aw_prev);
      end
      if (w_stall_prev) begin
        check("w_hold_valid", axi.wvalid, 1);
        check("w_hold_data", {axi.wdata, axi.wlast}, w_prev);
      end
      if (axi.awvalid && axi.awready) begin
        if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else check("awaddr", axi.awaddr, aw_q.pop_front());
        check("aw_const", {axi.awlen, axi.awsize, axi.awburst, axi.awid, axi.awlock, axi.awcache, axi.awprot},
              {8'd7, 3'b010, 2'b01, 4'd1, 2'b00, 4'd0, 3'b000});
        aw_seen = 1;
        aw_cyc  = cyc;
      end
      if (axi.wvalid && axi.wready) begin
        check("w_after_aw", aw_seen, 1);
        if (w_q.size() == 0) check("w_unexpected", 1, 0);
        else check("wdata_wlast", {axi.wdata, axi.wlast}, w_q.pop_front());
        check("w_const", {axi.wstrb, axi.wid}, {4'hF, 4'd1});
        line_w_cnt++;
        if (line_w_cnt == 1) first_w_cyc = cyc;
      end
      if (line_if.line_done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("line_err", line_if.line_err, done_q.pop_front());
        check("w_beats", line_w_cnt, 8);
        line_w_cnt = 0;
        aw_seen    = 0;
      end
      if (axi.awvalid || axi.wvalid) axi_act_cnt++;
      aw_stall_prev = axi.awvalid && !axi.awready;
      aw_prev       = axi.awaddr;
      w_stall_prev  = axi.wvalid && !axi.wready;
      w_prev        = {axi.wdata, axi.wlast};
    end
  end

  task automatic push_line(input logic [31:0] awaddr, input logic [255:0] data, input logic err);
    aw_q.push_back(awaddr);
    for (int i = 0; i < 8; i++) w_q.push_back({data[32*i +: 32], (i == 7)});
    done_q.push_back(err);
  endtask

  task automatic issue(input logic [26:0] paddr, input logic [255:0] data, input bit hold,
                       output int ack_c);
    int i;
    @(posedge clk);
    #1;
    line_if.line_req   = 1'b1;
    line_if.line_paddr = paddr;
    line_if.line_data  = data;
    ack_c = -1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (line_if.line_ack) begin
        ack_c = cyc;
        break;
      end
    end
    if (ack_c < 0) check("ack_timeout", 0, 1);
    if (!hold) begin
      @(posedge clk);
      #1;
      line_if.line_req = 1'b0;
    end
  endtask

  task automatic wait_done(output int done_c);
    int i;
    done_c = -1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (line_if.line_done) begin
        done_c = cyc;
        break;
      end
    end
    if (done_c < 0) check("done_timeout", 0, 1);
  endtask

  function automatic logic [255:0] mk_data(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = base + step * i;
    return d;
  endfunction

  initial begin
    int a, d, a2, act0, k;
    logic [255:0] da, db;
    rst = 1'b1;
    line_if.line_req   = 1'b0;
    line_if.line_paddr = '0;
    line_if.line_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_bready", axi.bready, 0);
    check("rst_ack", line_if.line_ack, 0);
    check("rst_done", {line_if.line_done, line_if.line_err}, 0);
    check("rst_busy", line_if.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: zero-wait slave, cycle-exact timing
    da = mk_data(32'h0, 32'h11111111);
    push_line(32'h00002460, da, 1'b0);
    issue(27'h0000123, da, 0, a);
    wait_done(d);
    check("t1_aw_cycle", aw_cyc - a, 1);
    check("t1_first_w_cycle", first_w_cyc - a, 2);
    check("t1_done_cycle", d - a, 10);
    @(negedge clk);
    check("t1_busy_after", line_if.busy, 0);

    // 2: AW stalled 3 cycles, W ready alternating
    aw_wait = 3;
    w_alt   = 1;
    da = mk_data(32'hC0DE0000, 32'h1);
    push_line(32'h1579BC20, da, 1'b0);
    issue(27'h0ABCDE1, da, 0, a);
    wait_done(d);
    check("t2_aw_stall_len", aw_cyc - a, 4);
    w_alt = 0;

    // 3: SLVERR response
    resp_mode = 2'b10;
    da = mk_data(32'h0BAD0000, 32'h10);
    push_line(32'h00000020, da, 1'b1);
    issue(27'h0000001, da, 0, a);
    wait_done(d);
    @(negedge clk);
    check("t3_idle_after_err", {line_if.busy, line_if.line_done, line_if.line_err}, 0);
    resp_mode = 2'b00;

    // 4: back-to-back lines with line_req held
    da = mk_data(32'hA0000000, 32'h1);
    db = mk_data(32'hB0000000, 32'h1);
    push_line(32'h00002000, da, 1'b0);
    push_line(32'h00004000, db, 1'b0);
    issue(27'h0000100, da, 1, a);
    @(posedge clk);
    #1;
    line_if.line_paddr = 27'h0000200;
    line_if.line_data  = db;
    d = -1;
    a2 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (line_if.line_done && d < 0) begin
        d = cyc;
        check("t4_no_overlap", line_if.line_ack, 0);
      end
      if (line_if.line_ack) begin
        a2 = cyc;
        break;
      end
    end
    check("t4_second_ack", a2 - d, 1);
    @(posedge clk);
    #1;
    line_if.line_req = 1'b0;
    wait_done(d);

    // 5: reset while beat 4 is on the W channel
    da = mk_data(32'h50000000, 32'h1);
    push_line(32'h00006000, da, 1'b0);
    issue(27'h0000300, da, 0, a);
    k = 0;
    for (int i = 0; i < 50 && k < 4; i++) begin
      @(negedge clk);
      if (axi.wvalid && axi.wready) k++;
    end
    check("t5_reach_beat4", k, 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_valids", {axi.awvalid, axi.wvalid, axi.bready, line_if.busy, line_if.line_done}, 0);
    w_q.delete();
    done_q.delete();
    aw_seen    = 0;
    line_w_cnt = 0;
    da = mk_data(32'h60000000, 32'h1);
    push_line(32'h00006020, da, 1'b0);
    issue(27'h0000301, da, 0, a);
    wait_done(d);

    // 6: top-of-range address, then idle with no requests
    da = mk_data(32'hFFFF0000, 32'h1);
    push_line(32'hFFFFFFE0, da, 1'b0);
    issue(27'h7FFFFFF, da, 0, a);
    wait_done(d);
    @(negedge clk);
    act0 = axi_act_cnt;
    repeat (20) @(negedge clk);
    check("t6_no_axi_activity", axi_act_cnt - act0, 0);
    check("t6_idle_busy", line_if.busy, 0);

    check("sb_empty", aw_q.size() + w_q.size() + done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
